// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module     : fetch_pkg
// Description: Shared types and constants for the instruction fetch unit.
//              Holds the fetch FSM state encoding, the NOP instruction that is
//              injected into the IF/ID register, and the default reset PC.
// Revision   : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch FSM states:
  //   S_IDLE - first cycle after reset, no request issued
  //   S_WAIT - request outstanding (or being issued) at the current PC
  //   S_HOLD - response captured while decode stalled; word sits in buffer
  //   S_DROP - a redirected request is still in flight; its response is dropped
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] c_NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module     : fetch_unit
// Description: Single-outstanding-request instruction fetch stage. Issues
//              word-aligned requests to instruction memory, presents the
//              returned word (or a held copy) to the IF/ID register, and
//              handles decode stalls and branch redirects.
// Ports      : clk, rst (sync, active-low)
//              StallF, BranchTaken, BranchTarget  - pipeline control in
//              imem_req, imem_addr                 - memory request out
//              imem_rvalid, imem_rdata             - memory response in
//              Addr, Inst, StallD, FlushD          - IF/ID register control
//              MisalignF                           - only with FETCH_ALIGN_CHK_EN
// Config     : FETCH_ALIGN_CHK_EN - adds registered MisalignF output flagging
//              redirects whose target has nonzero low bits.
// Revision   : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Addr,
  output logic [31:0] Inst,
  output logic        StallD,
  output logic        FlushD
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic        MisalignF
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  r_buf;
  logic [31:0]  w_buf_next;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_inc;
  logic [31:0]  w_word;
  logic         w_fetch_valid;

  // Redirect targets are always forced to a word boundary.
  assign w_target = {BranchTarget[31:2], 2'b00};
  // Natural 32-bit wrap: 0xFFFF_FFFC + 4 -> 0x0000_0000.
  assign w_pc_inc = r_pc + 32'd4;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_buf   <= c_NOP_INSN;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_buf   <= w_buf_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. A redirect always wins over a stall.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_buf_next   = r_buf;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_WAIT;
        if (BranchTaken) w_pc_next = w_target;
      end
      S_WAIT: begin
        if (BranchTaken) begin
          w_pc_next = w_target;
          // With no response yet, the in-flight request must be drained.
          w_state_next = imem_rvalid ? S_WAIT : S_DROP;
        end else if (imem_rvalid) begin
          if (!StallF) begin
            w_pc_next = w_pc_inc;
          end else begin
            w_buf_next   = imem_rdata;
            w_state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (BranchTaken) begin
          w_pc_next    = w_target;
          w_state_next = S_WAIT;
        end else if (!StallF) begin
          w_pc_next    = w_pc_inc;
          w_state_next = S_WAIT;
        end
      end
      S_DROP: begin
        if (BranchTaken) w_pc_next = w_target;
        if (imem_rvalid) w_state_next = S_WAIT;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. Reset forces the IF/ID interface to a flushed NOP.
  // --------------------------------------------------------------------------
  always_comb begin
    w_word        = c_NOP_INSN;
    w_fetch_valid = 1'b0;
    case (r_state)
      S_WAIT: begin
        w_word        = imem_rdata;
        w_fetch_valid = imem_rvalid & ~StallF & ~BranchTaken;
      end
      S_HOLD: begin
        w_word        = r_buf;
        w_fetch_valid = ~StallF & ~BranchTaken;
      end
      default: begin
        w_word        = c_NOP_INSN;
        w_fetch_valid = 1'b0;
      end
    endcase
    if (!rst) w_fetch_valid = 1'b0;

    imem_req  = rst & (r_state == S_WAIT);
    imem_addr = r_pc;
    StallD    = rst & StallF & ~BranchTaken;
    FlushD    = ~rst | BranchTaken | (~w_fetch_valid & ~StallF);
    Inst      = (~StallD & ~FlushD) ? w_word : c_NOP_INSN;
    Addr      = rst ? r_pc : RESET_PC;
  end

`ifdef FETCH_ALIGN_CHK_EN
  logic r_misalign;

  // Each redirect re-evaluates the flag, so an aligned redirect clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else if (BranchTaken) begin
      r_misalign <= |BranchTarget[1:0];
    end
  end

  assign MisalignF = r_misalign;
`else
  // Low target bits are silently discarded in this build.
  logic w_unused_tgt_lsb;
  assign w_unused_tgt_lsb = ^BranchTarget[1:0];
`endif

endmodule : fetch_unit
`default_nettype wire
